// File: rtl/aes_mix_pkg.sv
// Shared types and GF(2^8) helpers for the AES MixColumns datapath.
// Polynomial 0x11B; every multiplier is built from xtime and XOR (no tables).
package aes_mix_pkg;

  localparam logic MODE_FWD = 1'b0;
  localparam logic MODE_INV = 1'b1;

  typedef logic [31:0] col_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul3(input logic [7:0] b);
    return xtime(b) ^ b;
  endfunction

  function automatic logic [7:0] gmul9(input logic [7:0] b);
    return xtime(xtime(xtime(b))) ^ b;
  endfunction

  function automatic logic [7:0] gmul11(input logic [7:0] b);
    return xtime(xtime(xtime(b))) ^ xtime(b) ^ b;
  endfunction

  function automatic logic [7:0] gmul13(input logic [7:0] b);
    return xtime(xtime(xtime(b))) ^ xtime(xtime(b)) ^ b;
  endfunction

  function automatic logic [7:0] gmul14(input logic [7:0] b);
    return xtime(xtime(xtime(b))) ^ xtime(xtime(b)) ^ xtime(b);
  endfunction

endpackage

// File: rtl/mix_column_unit.sv
// Combinational single-column MixColumns / InvMixColumns.
// Ports: col_in (byte 0 = MSB), inv (1 = inverse), col_out.
// Macro MIXCOL_INV_EN: when undefined the inverse matrix is not built and inv is ignored.
module mix_column_unit
  import aes_mix_pkg::*;
(
  input  logic [31:0] col_in,
  input  logic        inv,
  output logic [31:0] col_out
);

  logic [7:0] a0, a1, a2, a3;

  assign {a0, a1, a2, a3} = col_in;

  // Forward matrix by default, overridden by the inverse matrix when enabled.
  always_comb begin
    col_out = {xtime(a0) ^ gmul3(a1) ^ a2 ^ a3,
               a0 ^ xtime(a1) ^ gmul3(a2) ^ a3,
               a0 ^ a1 ^ xtime(a2) ^ gmul3(a3),
               gmul3(a0) ^ a1 ^ a2 ^ xtime(a3)};
`ifdef MIXCOL_INV_EN
    if (inv == MODE_INV) begin
      col_out = {gmul14(a0) ^ gmul11(a1) ^ gmul13(a2) ^ gmul9(a3),
                 gmul9(a0) ^ gmul14(a1) ^ gmul11(a2) ^ gmul13(a3),
                 gmul13(a0) ^ gmul9(a1) ^ gmul14(a2) ^ gmul11(a3),
                 gmul11(a0) ^ gmul13(a1) ^ gmul9(a2) ^ gmul14(a3)};
    end
`endif
  end

`ifndef MIXCOL_INV_EN
  logic unused_inv;
  assign unused_inv = inv;
`endif

endmodule

// File: rtl/mixcolumns_seq.sv
// Sequential AES MixColumns / InvMixColumns, COLS_PER_CYCLE columns per clock.
// Ports: clk, rst (sync, active-high); in_valid/in_ready/in_mode/in_state input handshake;
//        out_valid/out_ready/out_state/out_mode output handshake. Column c = bits [127-32c -: 32].
// Macro MIXCOL_INV_EN: builds the inverse datapath; undefined -> forward only, out_mode = 0.
module mixcolumns_seq
  import aes_mix_pkg::*;
#(
  parameter int unsigned COLS_PER_CYCLE = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic         in_mode,
  input  logic [127:0] in_state,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_state,
  output logic         out_mode
);

  localparam int unsigned N_GROUPS = 4 / COLS_PER_CYCLE;
  localparam int unsigned CNT_W    = (N_GROUPS > 1) ? $clog2(N_GROUPS) : 1;

  if (!(COLS_PER_CYCLE == 1 || COLS_PER_CYCLE == 2 || COLS_PER_CYCLE == 4)) begin : g_bad_cfg
    $error("mixcolumns_seq: COLS_PER_CYCLE must be 1, 2 or 4");
  end

  state_e             state_q, state_d;
  logic [127:0]       work_q, work_d;
  logic               mode_q, mode_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               out_valid_q, out_valid_d;
  logic               in_mode_eff;
  logic               accept;
  logic               last_grp;
  col_t               unit_in  [COLS_PER_CYCLE];
  col_t               unit_out [COLS_PER_CYCLE];

`ifdef MIXCOL_INV_EN
  assign in_mode_eff = in_mode;
  assign out_mode    = mode_q;
`else
  logic unused_in_mode;
  assign unused_in_mode = in_mode;
  assign in_mode_eff    = MODE_FWD;
  assign out_mode       = MODE_FWD;
`endif

  // Ready depends on out_ready in DONE so a new job can be taken as the result leaves.
  assign in_ready  = !rst && ((state_q == IDLE) || ((state_q == DONE) && out_ready));
  assign accept    = in_valid && in_ready;
  assign last_grp  = (cnt_q == CNT_W'(N_GROUPS - 1));
  assign out_valid = out_valid_q;
  assign out_state = work_q;

  // Column-select mux: group g feeds columns g*COLS_PER_CYCLE + k.
  always_comb begin
    for (int unsigned k = 0; k < COLS_PER_CYCLE; k++) begin
      unit_in[k] = work_q[127 - 32*(32'(cnt_q)*COLS_PER_CYCLE + k) -: 32];
    end
  end

  for (genvar k = 0; k < COLS_PER_CYCLE; k++) begin : g_unit
    mix_column_unit u_mix (
      .col_in  (unit_in[k]),
      .inv     (mode_q),
      .col_out (unit_out[k])
    );
  end

  // Next-state and datapath update.
  always_comb begin
    state_d     = state_q;
    work_d      = work_q;
    mode_d      = mode_q;
    cnt_d       = cnt_q;
    out_valid_d = out_valid_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          work_d  = in_state;
          mode_d  = in_mode_eff;
          cnt_d   = '0;
          state_d = BUSY;
        end
      end
      BUSY: begin
        for (int unsigned k = 0; k < COLS_PER_CYCLE; k++) begin
          work_d[127 - 32*(32'(cnt_q)*COLS_PER_CYCLE + k) -: 32] = unit_out[k];
        end
        cnt_d = cnt_q + CNT_W'(1);
        if (last_grp) begin
          state_d     = DONE;
          out_valid_d = 1'b1;
        end
      end
      DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          if (accept) begin
            work_d  = in_state;
            mode_d  = in_mode_eff;
            cnt_d   = '0;
            state_d = BUSY;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      work_q      <= '0;
      mode_q      <= MODE_FWD;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      work_q      <= work_d;
      mode_q      <= mode_d;
      cnt_q       <= cnt_d;
      out_valid_q <= out_valid_d;
    end
  end

endmodule

// File: tb/tb_mixcolumns_seq.sv
// Self-checking bench for mixcolumns_seq: one instance per COLS_PER_CYCLE (1, 2, 4),
// scoreboard queues filled on acceptance and drained on output handshakes.
module tb_mixcolumns_seq;

  localparam logic [127:0] FIPS_A = 128'hdb135345_f20a225c_01010101_c6c6c6c6;
  localparam logic [127:0] FIPS_B = 128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6;
  localparam logic [127:0] D4_IN  = 128'hd4d4d4d5_00000000_00000000_00000000;
  localparam logic [127:0] D5_IN  = 128'hd5d5d7d6_00000000_00000000_00000000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Generic shift-and-add GF(2^8) multiply, 0x11B.
  function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = 8'h00;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [127:0] model(input logic [127:0] s, input logic inv);
    logic [7:0]   base [4];
    logic [127:0] r;
    logic [7:0]   acc;
    r = '0;
    if (inv) base = '{8'h0e, 8'h0b, 8'h0d, 8'h09};
    else     base = '{8'h02, 8'h03, 8'h01, 8'h01};
    for (int c = 0; c < 4; c++) begin
      for (int row = 0; row < 4; row++) begin
        acc = 8'h00;
        for (int j = 0; j < 4; j++) begin
          acc = acc ^ gm(base[(j - row + 4) % 4], s[127 - 32*c - 8*j -: 8]);
        end
        r[127 - 32*c - 8*row -: 8] = acc;
      end
    end
    return r;
  endfunction

  function automatic logic eff(input logic md);
`ifdef MIXCOL_INV_EN
    return md;
`else
    return md & 1'b0;
`endif
  endfunction

  for (genvar gi = 0; gi < 3; gi++) begin : g_inst
    localparam int C = (gi == 0) ? 1 : ((gi == 1) ? 2 : 4);
    localparam int N = 4 / C;

    logic         rst, in_valid, in_ready, in_mode, out_valid, out_ready, out_mode;
    logic [127:0] in_state, out_state;
    logic [127:0] exp_q [$];
    logic         md_q  [$];
    int           acc_q [$];
    logic         prev_v = 1'b0;
    bit           fin = 1'b0;

    mixcolumns_seq #(.COLS_PER_CYCLE(C)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_mode   (in_mode),
      .in_state  (in_state),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_state (out_state),
      .out_mode  (out_mode)
    );

    // Drive a transaction until accepted; expected result is queued at acceptance.
    task automatic send(input logic [127:0] st, input logic md, input logic [127:0] exp,
                        input bit rnd, output int waited);
      bit done_acc;
      done_acc = 1'b0;
      waited   = 0;
      in_valid = 1'b1;
      in_state = st;
      in_mode  = md;
      while (!done_acc) begin
        @(negedge clk);
        if (in_ready) begin
          exp_q.push_back(exp);
          md_q.push_back(eff(md));
          acc_q.push_back(cyc + 1);
          done_acc = 1'b1;
        end else if (waited > 64) begin
          check($sformatf("c%0d_accept_timeout", C), 128'(in_ready), 128'd1);
          done_acc = 1'b1;
        end else begin
          waited++;
        end
        @(posedge clk);
        #1;
        if (rnd) out_ready = 1'($urandom_range(0, 1));
      end
      in_valid = 1'b0;
      in_state = {$urandom, $urandom, $urandom, $urandom};
      in_mode  = 1'($urandom_range(0, 1));
    endtask

    task automatic drain();
      int t;
      t = 0;
      out_ready = 1'b1;
      forever begin
        @(negedge clk);
        #1;
        if (exp_q.size() == 0) break;
        if (t > 200) begin
          check($sformatf("c%0d_drain_timeout", C), 128'(exp_q.size()), 128'd0);
          exp_q.delete(); md_q.delete(); acc_q.delete();
          break;
        end
        t++;
      end
      @(posedge clk);
      #1;
    endtask

    // Scoreboard side: latency on each rising out_valid, data on each output handshake.
    always @(negedge clk) begin
      if (!rst) begin
        if (out_valid && !prev_v) begin
          if (acc_q.size() == 0) check($sformatf("c%0d_spurious_valid", C), 128'(out_valid), 128'd0);
          else check($sformatf("c%0d_latency", C), 128'(cyc - acc_q[0]), 128'(N));
        end
        if (out_valid && out_ready && exp_q.size() != 0) begin
          check($sformatf("c%0d_out_state", C), out_state, exp_q[0]);
          check($sformatf("c%0d_out_mode", C), 128'(out_mode), 128'(md_q[0]));
          void'(exp_q.pop_front());
          void'(md_q.pop_front());
          void'(acc_q.pop_front());
        end
      end
      prev_v <= out_valid;
    end

    initial begin
      int w;
      logic [127:0] st, e1;
      logic md;
      rst = 1'b1; in_valid = 1'b0; in_mode = 1'b0; in_state = '0; out_ready = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check($sformatf("c%0d_rst_in_ready", C), 128'(in_ready), 128'd0);
      check($sformatf("c%0d_rst_out_valid", C), 128'(out_valid), 128'd0);
      check($sformatf("c%0d_rst_out_state", C), out_state, 128'd0);
      check($sformatf("c%0d_rst_out_mode", C), 128'(out_mode), 128'd0);
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      check($sformatf("c%0d_idle_in_ready", C), 128'(in_ready), 128'd1);
      @(posedge clk); #1;

      // Known-answer vectors, forward and inverse.
      send(FIPS_A, 1'b0, FIPS_B, 1'b0, w); drain();
      send(FIPS_B, 1'b1, eff(1'b1) ? FIPS_A : model(FIPS_B, 1'b0), 1'b0, w); drain();
      send(D4_IN, 1'b0, D5_IN, 1'b0, w); drain();
      send(D5_IN, 1'b1, eff(1'b1) ? D4_IN : model(D5_IN, 1'b0), 1'b0, w); drain();
      send('0, 1'b0, '0, 1'b0, w); drain();
      send('1, 1'b1, '1, 1'b0, w); drain();
      send('1, 1'b0, '1, 1'b0, w); drain();

      // Backpressure then back-to-back acceptance.
      out_ready = 1'b0;
      st = {$urandom, $urandom, $urandom, $urandom};
      e1 = model(st, 1'b0);
      send(st, 1'b0, e1, 1'b0, w);
      w = 0;
      while (!out_valid && w < 64) begin @(negedge clk); w++; end
      check($sformatf("c%0d_bp_reach_valid", C), 128'(out_valid), 128'd1);
      for (int k = 0; k < 5; k++) begin
        @(negedge clk);
        check($sformatf("c%0d_bp_valid", C), 128'(out_valid), 128'd1);
        check($sformatf("c%0d_bp_state", C), out_state, e1);
        check($sformatf("c%0d_bp_in_ready", C), 128'(in_ready), 128'd0);
      end
      @(posedge clk); #1;
      out_ready = 1'b1;
      st = {$urandom, $urandom, $urandom, $urandom};
      send(st, 1'b1, model(st, eff(1'b1)), 1'b0, w);
      check($sformatf("c%0d_b2b_no_gap", C), 128'(w), 128'd0);
      drain();

      // Reset two cycles after acceptance aborts the transaction.
      out_ready = 1'b0;
      send(FIPS_A, 1'b0, FIPS_B, 1'b0, w);
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
      check($sformatf("c%0d_abort_valid", C), 128'(out_valid), 128'd0);
      check($sformatf("c%0d_abort_state", C), out_state, 128'd0);
      check($sformatf("c%0d_abort_in_ready", C), 128'(in_ready), 128'd0);
      exp_q.delete(); md_q.delete(); acc_q.delete();
      @(posedge clk); #1;
      rst = 1'b0;
      out_ready = 1'b1;
      @(negedge clk);
      check($sformatf("c%0d_post_abort_in_ready", C), 128'(in_ready), 128'd1);
      @(posedge clk); #1;
      send(FIPS_A, 1'b0, FIPS_B, 1'b0, w); drain();

      // Mode is latched at acceptance.
      st = {$urandom, $urandom, $urandom, $urandom};
      send(st, 1'b1, model(st, eff(1'b1)), 1'b0, w);
      for (int k = 0; k < N + 2; k++) begin
        in_mode = ~in_mode;
        @(posedge clk); #1;
      end
      drain();

      // Random equivalence with random downstream readiness.
      for (int k = 0; k < 1000; k++) begin
        st = {$urandom, $urandom, $urandom, $urandom};
        md = 1'($urandom_range(0, 1));
        send(st, md, model(st, eff(md)), 1'b1, w);
      end
      drain();
      fin = 1'b1;
    end
  end

  initial begin
    int t;
    t = 0;
    while (!(g_inst[0].fin && g_inst[1].fin && g_inst[2].fin) && t < 60000) begin
      @(posedge clk);
      t++;
    end
    if (t >= 60000) check("global_timeout", 128'(t), 128'd0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
